// File: rtl/servo_pkg.sv
// Shared constants and command decoding for the per-joint servo drive stage.
package servo_pkg;

  // Default timing in microseconds, for a 100 MHz system clock.
  localparam int DEF_CLK_PER_US = 100;
  localparam int DEF_PERIOD_US  = 20000;
  localparam int DEF_MIN_US     = 500;
  localparam int DEF_MAX_US     = 2500;
  localparam int DEF_CENTER_US  = 1500;
  localparam int DEF_STEP_US    = 10;

  // Width of the commanded pulse width in microseconds.
  localparam int POS_W = 12;

  // The two hold commands, viewed together as {clockwise, counter-clockwise}.
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_CCW  = 2'b01,
    CMD_CW   = 2'b10,
    CMD_BOTH = 2'b11
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic cw, input logic ccw);
    return cmd_e'({cw, ccw});
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Prescaler: divides clk down to a one-cycle microsecond tick.
module us_tick_gen #(
  parameter int CLK_PER_US = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic us_tick_o,
  output logic presc_zero_o
);

  localparam int            PW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Next count: wrap to zero after the last cycle of each microsecond.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (presc_q == LAST) presc_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk_i) begin
    if (rst_i) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  assign us_tick_o    = (presc_q == LAST);
  assign presc_zero_o = (presc_q == '0);

endmodule

// File: rtl/servo_step_pwm.sv
// Per-joint servo drive: hold commands step a saturating position that is
// latched at frame boundaries and rendered as a 50 Hz hobby-servo PWM.
module servo_step_pwm
  import servo_pkg::*;
#(
  parameter int CLK_PER_US  = DEF_CLK_PER_US,
  parameter int PERIOD_US   = DEF_PERIOD_US,
  parameter int MIN_US      = DEF_MIN_US,
  parameter int MAX_US      = DEF_MAX_US,
  parameter int CENTER_US   = DEF_CENTER_US,
  parameter int STEP_US     = DEF_STEP_US,
  parameter int STEP_FRAMES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             isClockWise,
  input  logic             isCounterClock,
  output logic             servo,
  output logic [POS_W-1:0] position,
  output logic             frame_start,
  output logic             at_min,
  output logic             at_max
);

  if (!(MIN_US <= CENTER_US && CENTER_US <= MAX_US && MAX_US < PERIOD_US &&
        MAX_US < 4096 && PERIOD_US < 65536 && CLK_PER_US >= 1 &&
        STEP_FRAMES >= 1 && STEP_US >= 0)) begin : g_bad_params
    $error("servo_step_pwm: inconsistent timing parameters");
  end

  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0]        FRAME_LAST = CNT_W'(PERIOD_US - 1);
  localparam logic [CNT_W-1:0]        STEP_LAST  = CNT_W'(STEP_FRAMES - 1);
  localparam logic [POS_W-1:0]        CENTER_P   = POS_W'(CENTER_US);
  localparam logic [POS_W-1:0]        MIN_P      = POS_W'(MIN_US);
  localparam logic [POS_W-1:0]        MAX_P      = POS_W'(MAX_US);
  localparam logic signed [POS_W:0]   MIN_S      = (POS_W+1)'(MIN_US);
  localparam logic signed [POS_W:0]   MAX_S      = (POS_W+1)'(MAX_US);
  localparam logic signed [POS_W:0]   STEP_S     = (POS_W+1)'(STEP_US);

  // One step in 13-bit signed arithmetic, saturated onto [MIN_US, MAX_US].
  function automatic logic [POS_W-1:0] sat_step(input logic [POS_W-1:0] pos,
                                                input logic             up);
    logic signed [POS_W:0] cur;
    logic signed [POS_W:0] nxt;
    cur = $signed({1'b0, pos});
    if (up) begin
      nxt = cur + STEP_S;
      if (nxt > MAX_S) nxt = MAX_S;
    end else begin
      nxt = cur - STEP_S;
      if (nxt < MIN_S) nxt = MIN_S;
    end
    return nxt[POS_W-1:0];
  endfunction

  logic             us_tick, presc_zero, frame_end;
  cmd_e             cmd;
  logic [CNT_W-1:0] us_cnt_q, us_cnt_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [POS_W-1:0] position_q, position_d;
  logic [POS_W-1:0] width_q, width_d;
  logic             servo_q, servo_d;
  logic             frame_start_q, frame_start_d;

  us_tick_gen #(
    .CLK_PER_US (CLK_PER_US)
  ) u_us_tick_gen (
    .clk_i        (clk),
    .rst_i        (rst),
    .us_tick_o    (us_tick),
    .presc_zero_o (presc_zero)
  );

  assign frame_end = us_tick && (us_cnt_q == FRAME_LAST);
  assign cmd       = decode_cmd(isClockWise, isCounterClock);

  // Microsecond-in-frame counter, wrapping at the frame end.
  always_comb begin
    us_cnt_d = us_cnt_q;
    if (frame_end)    us_cnt_d = '0;
    else if (us_tick) us_cnt_d = us_cnt_q + CNT_W'(1);
  end

  // Frame-end step logic: commands only matter on the frame-end cycle, and the
  // resulting position is latched as the pulse width for the coming frame.
  always_comb begin
    step_cnt_d = step_cnt_q;
    position_d = position_q;
    width_d    = width_q;
    if (frame_end) begin
      if (cmd == CMD_CW || cmd == CMD_CCW) begin
        if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = '0;
          position_d = sat_step(position_q, cmd == CMD_CW);
        end else begin
          step_cnt_d = step_cnt_q + CNT_W'(1);
        end
      end else begin
        step_cnt_d = '0;
      end
      width_d = position_d;
    end
  end

  // PWM compare and frame marker; both look at the same pre-edge counter state
  // so frame_start lines up with the first high cycle of servo.
  always_comb begin
    servo_d       = (us_cnt_q < {{(CNT_W-POS_W){1'b0}}, width_q});
    frame_start_d = (us_cnt_q == '0) && presc_zero;
  end

  // ---- register stage: counters, position, latched width, PWM output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt_q      <= '0;
      step_cnt_q    <= '0;
      position_q    <= CENTER_P;
      width_q       <= CENTER_P;
      servo_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      us_cnt_q      <= us_cnt_d;
      step_cnt_q    <= step_cnt_d;
      position_q    <= position_d;
      width_q       <= width_d;
      servo_q       <= servo_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign servo       = servo_q;
  assign position    = position_q;
  assign frame_start = frame_start_q;
  assign at_min      = (position_q == MIN_P);
  assign at_max      = (position_q == MAX_P);

endmodule

// File: tb/tb_servo_step_pwm.sv
// Bench for servo_step_pwm: two instances (STEP_FRAMES 1 and 3) share stimulus
// and are compared every cycle against a frame/phase-based reference model.
module tb_servo_step_pwm;

  localparam int CPU   = 2;
  localparam int PER   = 40;
  localparam int MINW  = 4;
  localparam int MAXW  = 16;
  localparam int CEN   = 10;
  localparam int STEP  = 2;
  localparam int FRAME = CPU * PER;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cw  = 1'b0;
  logic        ccw = 1'b0;
  logic [1:0]  servo_w, fs_w, amin_w, amax_w;
  logic [11:0] pos_w [2];

  always #5 clk = ~clk;

  servo_step_pwm #(
    .CLK_PER_US(CPU), .PERIOD_US(PER), .MIN_US(MINW), .MAX_US(MAXW),
    .CENTER_US(CEN), .STEP_US(STEP), .STEP_FRAMES(1)
  ) u_dut_sf1 (
    .clk(clk), .rst(rst), .isClockWise(cw), .isCounterClock(ccw),
    .servo(servo_w[0]), .position(pos_w[0]), .frame_start(fs_w[0]),
    .at_min(amin_w[0]), .at_max(amax_w[0])
  );

  servo_step_pwm #(
    .CLK_PER_US(CPU), .PERIOD_US(PER), .MIN_US(MINW), .MAX_US(MAXW),
    .CENTER_US(CEN), .STEP_US(STEP), .STEP_FRAMES(3)
  ) u_dut_sf3 (
    .clk(clk), .rst(rst), .isClockWise(cw), .isCounterClock(ccw),
    .servo(servo_w[1]), .position(pos_w[1]), .frame_start(fs_w[1]),
    .at_min(amin_w[1]), .at_max(amax_w[1])
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model state: k counts clock edges since reset was released.
  int k = 0;
  int sf[2] = '{1, 3};
  int m_pos[2];
  int m_wid[2];
  int m_cnt[2];
  int hi_cnt[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, then compare.
  task automatic tick(input logic c_cw, input logic c_ccw, input logic c_rst);
    bit exp_servo[2];
    bit exp_fs;
    bit fend;
    int old_w[2];
    cw  = c_cw;
    ccw = c_ccw;
    rst = c_rst;
    fend = 1'b0;
    exp_fs = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_servo[i] = 1'b0;
      old_w[i]     = m_wid[i];
    end
    if (c_rst) begin
      for (int i = 0; i < 2; i++) begin
        m_pos[i] = CEN; m_wid[i] = CEN; m_cnt[i] = 0; hi_cnt[i] = 0;
      end
      k = 0;
    end else begin
      exp_fs = ((k % FRAME) == 0);
      for (int i = 0; i < 2; i++)
        exp_servo[i] = (((k % FRAME) / CPU) < m_wid[i]);
      if ((k % FRAME) == FRAME - 1) begin
        fend = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (c_cw != c_ccw) begin
            m_cnt[i]++;
            if (m_cnt[i] == sf[i]) begin
              m_cnt[i] = 0;
              if (c_cw) m_pos[i] = (m_pos[i] + STEP > MAXW) ? MAXW : m_pos[i] + STEP;
              else      m_pos[i] = (m_pos[i] - STEP < MINW) ? MINW : m_pos[i] - STEP;
            end
          end else begin
            m_cnt[i] = 0;
          end
          m_wid[i] = m_pos[i];
        end
      end
      k++;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("servo%0d", i), 32'(servo_w[i]), 32'(exp_servo[i]));
      check($sformatf("position%0d", i), 32'(pos_w[i]), 32'(m_pos[i]));
      check($sformatf("frame_start%0d", i), 32'(fs_w[i]), 32'(exp_fs));
      check($sformatf("at_min%0d", i), 32'(amin_w[i]), 32'(m_pos[i] == MINW));
      check($sformatf("at_max%0d", i), 32'(amax_w[i]), 32'(m_pos[i] == MAXW));
      if (!c_rst) begin
        hi_cnt[i] += int'(servo_w[i]);
        if (fend) begin
          check($sformatf("high_time%0d", i), 32'(hi_cnt[i]), 32'(CPU * old_w[i]));
          hi_cnt[i] = 0;
        end
      end
    end
  endtask

  task automatic run(input int n, input logic c_cw, input logic c_ccw);
    for (int c = 0; c < n; c++) tick(c_cw, c_ccw, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = CEN; m_wid[i] = CEN; m_cnt[i] = 0; hi_cnt[i] = 0;
    end

    // Reset, then three idle frames at the centre width.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    run(3 * FRAME, 1'b0, 1'b0);
    check("idle_pos", 32'(pos_w[0]), 32'd10);

    // Clockwise held across four frame ends: saturates at MAX.
    run(4 * FRAME, 1'b1, 1'b0);
    run(FRAME, 1'b0, 1'b0);
    check("cw_pos_sf1", 32'(pos_w[0]), 32'd16);
    check("cw_atmax_sf1", 32'(amax_w[0]), 32'd1);
    check("cw_pos_sf3", 32'(pos_w[1]), 32'd12);

    // Counter-clockwise held long enough to reach MIN.
    run(7 * FRAME, 1'b0, 1'b1);
    run(FRAME, 1'b0, 1'b0);
    check("ccw_pos_sf1", 32'(pos_w[0]), 32'd4);
    check("ccw_atmin_sf1", 32'(amin_w[0]), 32'd1);
    check("ccw_pos_sf3", 32'(pos_w[1]), 32'd8);

    // Both commands held, then a short mid-frame clockwise pulse: no change.
    run(2 * FRAME, 1'b1, 1'b1);
    run(30, 1'b0, 1'b0);
    run(10, 1'b1, 1'b0);
    run(FRAME - 40, 1'b0, 1'b0);
    run(FRAME, 1'b0, 1'b0);
    check("glitch_pos_sf1", 32'(pos_w[0]), 32'd4);
    check("glitch_pos_sf3", 32'(pos_w[1]), 32'd8);

    // Step up, then reset at cycle 37 of a frame.
    run(5 * FRAME, 1'b1, 1'b0);
    run(37, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_pos", 32'(pos_w[0]), 32'd10);
    check("rst_servo", 32'(servo_w[0]), 32'd0);
    run(2 * FRAME, 1'b0, 1'b0);

    // Randomized commands, mostly held per frame with occasional glitches and resets.
    for (int f = 0; f < 150; f++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int c = 0; c < FRAME; c++) begin
        logic r_cw, r_ccw, r_rst;
        r_cw  = mode[1];
        r_ccw = mode[0];
        if ($urandom_range(0, 9) == 0) begin
          r_cw  = 1'($urandom_range(0, 1));
          r_ccw = 1'($urandom_range(0, 1));
        end
        r_rst = ($urandom_range(0, 2999) == 0);
        tick(r_cw, r_ccw, r_rst);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/servo_step_pwm.md
# servo_step_pwm

Per-joint servo drive stage: it turns the debounced clockwise/counter-clockwise hold commands into a saturating position register and a glitch-free 50 Hz hobby-servo PWM waveform. It sits directly downstream of the keyboard/Bluetooth command decode in the arm top level, with one instance per joint. Position changes only at PWM frame boundaries, so a pulse is never truncated or stretched mid-frame.

## Interface
- CLK_PER_US, default 100: clk cycles per microsecond tick (100 MHz clk).
- PERIOD_US, default 20000: PWM frame length in µs.
- MIN_US, default 500: minimum pulse width in µs.
- MAX_US, default 2500: maximum pulse width in µs.
- CENTER_US, default 1500: reset pulse width in µs.
- STEP_US, default 10: position change per step in µs.
- STEP_FRAMES, default 1: number of frames a command must be held per step.
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- isClockWise  in  1  level command: increase width. Already in the clk domain.
- isCounterClock  in  1  level command: decrease width.
- servo  out  1  PWM output, registered.
- position  out  12  current commanded width in µs.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- at_min / at_max  out  1  each  position == MIN_US / position == MAX_US.

## Operation
- Prescaler counts 0..CLK_PER_US-1. us_tick is high on the cycle where the count is CLK_PER_US-1.
- us_cnt counts 0..PERIOD_US-1 and advances on us_tick. Frame end is the cycle where us_tick is high and us_cnt == PERIOD_US-1.
- Frame-end actions, all on the same edge:
  - Sample the commands. Exactly one active: step_cnt++. None or both active: step_cnt <= 0 and no step.
  - If step_cnt == STEP_FRAMES-1 and exactly one command is active, apply the step and clear step_cnt:
    - clockwise: position <= min(position+STEP_US, MAX_US)
    - counter-clockwise: position <= max(position-STEP_US, MIN_US)
  - width_lat <= the new position value.
- servo <= (us_cnt < width_lat), registered every cycle.
- Arithmetic is 13-bit internally, so position+STEP_US cannot overflow before the clamp. A step that would cross a limit lands exactly on the limit.
- Commands are ignored between frame ends. A press shorter than one frame that misses the frame end has no effect.
- Reset mid-frame aborts the frame; the next frame starts on the first cycle after reset.

## Timing
- Reset values: servo=0, position=CENTER_US, width_lat=CENTER_US, step_cnt=0, prescaler=0, us_cnt=0, frame_start=0, at_min/at_max derived from position.
- First edge after rst falls: servo=1, frame_start=1. frame_start is high whenever the registered us_cnt==0 and the prescaler==0.
- Frame length is exactly PERIOD_US*CLK_PER_US cycles. High time is exactly width_lat*CLK_PER_US cycles.
- Latency: a command held across frame end N changes the pulse width of frame N+1. With STEP_FRAMES=k, the first step lands k frame ends after the press.
- position, at_min and at_max update on the frame-end edge and are stable for the whole frame.

## Structure
- Package servo_pkg: default timing constants (CLK_PER_US, PERIOD_US, MIN_US, MAX_US, CENTER_US, STEP_US) and the POS_W=12 width constant.
- Sub-module us_tick_gen: prescaler producing us_tick.
- Frame counter, step logic and PWM compare live in the top module.
- Elaboration check: MIN_US ≤ CENTER_US ≤ MAX_US < PERIOD_US, and MAX_US < 4096.

## Test plan
Parameters for all scenarios: CLK_PER_US=2, PERIOD_US=40, MIN_US=4, MAX_US=16, CENTER_US=10, STEP_US=2, STEP_FRAMES=1 (frame = 80 cycles).
- Reset then idle, 3 frames -> each frame: servo high 20 cycles, low 60. position=10. frame_start every 80 cycles, first one on the first edge after reset.
- isClockWise held across 4 frame ends -> next frames high 24, 28, 32, 32 cycles. position reaches 16, at_max=1 from the third step onward.
- isCounterClock held for 5 frame ends -> position 8, 6, 4, 4, 4. at_min=1. Minimum high time 8 cycles.
- Both commands held, then a 10-cycle isClockWise pulse placed mid-frame (not covering frame end) -> position stays 10 and no width change.
- STEP_FRAMES=3, clockwise held for 5 frame ends -> a single step to 12 on the 3rd frame end. Release then re-press -> step_cnt restarts from 0.
- rst asserted at cycle 37 of a frame at position 14 -> position=10 and servo=0 while rst is high. Clean 80-cycle frame with 20 high cycles after release.
